// File: rtl/aes_pkg.sv
// Shared AES definitions for the InvSubBytes engine: FSM encoding, state
// geometry and the byte-ordering helper for 128-bit states.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} isb_state_t;

  localparam int AES_BYTES = 16;

  // Byte 0 of a state is the most significant byte. With the state viewed
  // as logic [15:0][7:0], byte i therefore lives at packed index 15-i.
  function automatic logic [3:0] byte_pos(logic [3:0] i);
    return 4'(AES_BYTES - 1) - i;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Input/output handshake bundle of the InvSubBytes engine.
interface inv_sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out
  );

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );
endinterface

// File: rtl/inv_sub_bytes_seq_i_s_box.sv
// AES inverse S-box: pure 256-entry lookup, one byte in, one byte out.
module i_s_box (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes: LANES shared inverse S-boxes rewrite the state
// buffer in place, LANES bytes per cycle, then hold the result for a
// valid/ready handoff.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  inv_sub_bytes_seq_if.slave   bus,
  output logic                 busy
);

  localparam int CHUNKS = AES_BYTES / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  isb_state_t                   state_q, state_d;
  logic [AES_BYTES-1:0][7:0]    buf_q, buf_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic [3:0]                   base;
  logic [LANES-1:0][7:0]        lane_in;
  logic [LANES-1:0][7:0]        lane_out;

  // First byte index of the chunk currently being substituted.
  assign base = 4'(int'(cnt_q) * LANES);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_in[g] = buf_q[byte_pos(base + 4'(g))];
    i_s_box u_sbox (
      .din  (lane_in[g]),
      .dout (lane_out[g])
    );
  end

  // Next-state, buffer and chunk-counter logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          buf_d   = bus.state_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int g = 0; g < LANES; g++) begin
          buf_d[byte_pos(base + 4'(g))] = lane_out[g];
        end
        if (cnt_q == CW'(CHUNKS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      buf_d   = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  // state_out mirrors the buffer at all times; out_valid qualifies it.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.state_out = buf_q;
  assign busy          = (state_q == RUN) || (state_q == DONE);

endmodule
